// File: rtl/gsim_pkg.sv
// gsim shared definitions: FSM encoding,
// band coefficients and datapath depth.
package gsim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int C0   = 20;
  localparam int C1   = 13;
  localparam int C2   = 6;
  localparam int C3   = 1;
  localparam int PIPE = 4;

endpackage

// File: rtl/gsim_update_pe.sv
// gsim update element: band sum, exact floor
// divide by C0, saturate; result 3 cycles after issue.
module gsim_update_pe
  import gsim_pkg::*;
#(
  parameter int BW   = 16,
  parameter int FRAC = 16,
  parameter int XW   = BW + FRAC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [BW-1:0] b,
  input  logic signed [XW-1:0] xm1,
  input  logic signed [XW-1:0] xp1,
  input  logic signed [XW-1:0] xm2,
  input  logic signed [XW-1:0] xp2,
  input  logic signed [XW-1:0] xm3,
  input  logic signed [XW-1:0] xp3,
  output logic                 out_valid,
  output logic signed [XW-1:0] x_new
);

  localparam int NW = XW + 7;
  // S chosen so the reciprocal error stays
  // below 1/8: the estimate is off by at most 1.
  localparam int S  = NW + 2;
  localparam int PW = NW + S + 2;

  localparam logic [S:0] POW = {1'b1, {S{1'b0}}};
  localparam logic [S:0] RCP = POW / (S+1)'(C0);

  localparam logic signed [NW-1:0] K1 = NW'(C1);
  localparam logic signed [NW-1:0] K2 = NW'(C2);
  localparam logic signed [NW-1:0] K3 = NW'(C3);
  localparam logic signed [NW-1:0] ONE = NW'(1);
  localparam logic signed [NW+1:0] D20 = (NW+2)'(C0);
  localparam logic signed [NW-1:0] XMAX =
    NW'({1'b0, {(XW-1){1'b1}}});
  localparam logic signed [NW-1:0] XMIN = ~XMAX;

  logic signed [NW-1:0] num_d, num1_q, num2_q;
  logic signed [PW-1:0] prod_d;
  logic signed [NW-1:0] q0_d, q0_q, q_d, sat_d;
  logic signed [NW+1:0] rem;
  logic                 v1_q, v2_q;

  // stage 1 operand: banded numerator
  always_comb begin
    num_d = (NW'(b) <<< FRAC)
          + K1 * (NW'(xm1) + NW'(xp1))
          - K2 * (NW'(xm2) + NW'(xp2))
          + K3 * (NW'(xm3) + NW'(xp3));
  end

  // stage 2 operand: reciprocal quotient estimate
  always_comb begin
    prod_d = PW'(num1_q) * PW'($signed({1'b0, RCP}));
    q0_d   = NW'(prod_d >>> S);
  end

  // stage 3 operand: fix estimate, then clamp
  always_comb begin
    rem = (NW+2)'(num2_q) - (NW+2)'(q0_q) * D20;
    q_d = q0_q;
    if (rem < 0)
      q_d = q0_q - ONE;
    else if (rem >= D20)
      q_d = q0_q + ONE;
    sat_d = q_d;
    if (q_d > XMAX)
      sat_d = XMAX;
    else if (q_d < XMIN)
      sat_d = XMIN;
  end

  // three register stages with a valid chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num1_q    <= '0;
      num2_q    <= '0;
      q0_q      <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      x_new     <= '0;
    end else begin
      v1_q      <= in_valid;
      num1_q    <= num_d;
      v2_q      <= v1_q;
      num2_q    <= num1_q;
      q0_q      <= q0_d;
      out_valid <= v2_q;
      x_new     <= sat_d[XW-1:0];
    end
  end

endmodule

// File: rtl/gsim_param.sv
// gsim top: load b, Gauss-Seidel sweeps over
// the band, stream x with convergence status.
module gsim_param
  import gsim_pkg::*;
#(
  parameter int N        = 16,
  parameter int BW       = 16,
  parameter int FRAC     = 16,
  parameter int XW       = BW + FRAC,
  parameter int MAX_ITER = 127,
  parameter int TOL      = 2,
  localparam int IW      = $clog2(N),
  localparam int CW      = $clog2(MAX_ITER + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [BW-1:0] b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [XW-1:0] x_out,
  output logic [IW-1:0]        out_idx,
  output logic                 out_last,
  output logic                 converged,
  output logic [CW-1:0]        iter_count,
  output logic                 busy
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q;
  logic [1:0]           ph_q;
  logic [CW-1:0]        iter_q;
  logic                 conv_q, all_eq_q;
  logic signed [BW-1:0] b_q [N];
  logic signed [XW-1:0] x_q [N];

  logic signed [XW-1:0] xm1, xp1, xm2, xp2, xm3, xp3;
  logic signed [XW-1:0] pe_x;
  logic                 pe_issue, pe_valid;
  logic                 wr_eq, sweep_end;
  logic                 sweep_conv, iter_hit;
  int                   cur;

  assign cur        = int'(idx_q);
  assign pe_issue   = (state_q == ITER) && (ph_q == 2'd0);
  assign wr_eq      = pe_x[XW-1:TOL] == x_q[idx_q][XW-1:TOL];
  assign sweep_end  = (state_q == ITER) && (ph_q == 2'd3)
                   && (idx_q == LAST);
  assign sweep_conv = all_eq_q && wr_eq;
  assign iter_hit   = ({1'b0, iter_q} + 1'b1)
                   == (CW+1)'(MAX_ITER);

  assign in_ready   = (state_q == IDLE) || (state_q == LOAD);
  assign busy       = state_q != IDLE;
  assign out_valid  = state_q == OUT;
  assign x_out      = x_q[idx_q_out()];
  assign out_last   = out_valid && (out_idx == LAST);
  assign converged  = conv_q;
  assign iter_count = iter_q;

  logic [IW-1:0] oidx_q;
  assign out_idx = oidx_q;

  function automatic logic [IW-1:0] idx_q_out();
    return oidx_q;
  endfunction

  // neighbour x values, zero outside 0..N-1
  always_comb begin
    xm1 = '0; xp1 = '0;
    xm2 = '0; xp2 = '0;
    xm3 = '0; xp3 = '0;
    for (int k = 0; k < N; k++) begin
      if (k == cur - 1) xm1 = x_q[k];
      if (k == cur + 1) xp1 = x_q[k];
      if (k == cur - 2) xm2 = x_q[k];
      if (k == cur + 2) xp2 = x_q[k];
      if (k == cur - 3) xm3 = x_q[k];
      if (k == cur + 3) xp3 = x_q[k];
    end
  end

  gsim_update_pe #(
    .BW   (BW),
    .FRAC (FRAC),
    .XW   (XW)
  ) u_pe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pe_issue),
    .b         (b_q[idx_q]),
    .xm1       (xm1),
    .xp1       (xp1),
    .xm2       (xm2),
    .xp2       (xp2),
    .xm3       (xm3),
    .xp3       (xp3),
    .out_valid (pe_valid),
    .x_new     (pe_x)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = LOAD;
      LOAD: if (in_valid && idx_q == LAST)
              state_d = ITER;
      ITER: if (sweep_end && (sweep_conv || iter_hit))
              state_d = OUT;
      OUT:  if (out_ready && out_last)
              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // register files, sweep sequencing, convergence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      ph_q     <= '0;
      oidx_q   <= '0;
      iter_q   <= '0;
      conv_q   <= 1'b0;
      all_eq_q <= 1'b1;
      for (int k = 0; k < N; k++) begin
        b_q[k] <= '0;
        x_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          b_q[0] <= b_in;
          x_q[0] <= XW'(b_in) <<< FRAC;
          idx_q  <= IW'(1);
        end
        LOAD: if (in_valid) begin
          b_q[idx_q] <= b_in;
          x_q[idx_q] <= XW'(b_in) <<< FRAC;
          if (idx_q == LAST) begin
            idx_q    <= '0;
            ph_q     <= '0;
            iter_q   <= '0;
            conv_q   <= 1'b0;
            all_eq_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ITER: begin
          ph_q <= ph_q + 1'b1;
          if (pe_valid) begin
            x_q[idx_q] <= pe_x;
            if (!wr_eq) all_eq_q <= 1'b0;
          end
          if (ph_q == 2'd3) begin
            if (idx_q == LAST) begin
              idx_q    <= '0;
              iter_q   <= iter_q + 1'b1;
              conv_q   <= sweep_conv;
              all_eq_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        OUT: if (out_ready) begin
          if (oidx_q == LAST) oidx_q <= '0;
          else                oidx_q <= oidx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_param.sv
// gsim_param bench: directed and random problems
// against a floor-division Gauss-Seidel model.
module tb_gsim_param;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        iv16 = 0, ir16, ov16, or16 = 0;
  logic        last16, conv16, busy16;
  logic [15:0] b16 = '0;
  logic [31:0] x16;
  logic [3:0]  idx16;
  logic [6:0]  it16;

  logic        iv4 = 0, ir4, ov4, or4 = 0;
  logic        last4, conv4, busy4;
  logic [15:0] b4 = '0;
  logic [31:0] x4;
  logic [1:0]  idx4;
  logic [0:0]  it4;

  int checks = 0;
  int fails  = 0;

  longint mb [64];
  longint mx [64];
  int     m_it;
  bit     m_conv;

  always #5 clk = ~clk;

  gsim_param u16 (
    .clk(clk), .reset(reset),
    .in_valid(iv16), .in_ready(ir16), .b_in(b16),
    .out_valid(ov16), .out_ready(or16), .x_out(x16),
    .out_idx(idx16), .out_last(last16),
    .converged(conv16), .iter_count(it16),
    .busy(busy16)
  );

  gsim_param #(.N(4), .MAX_ITER(1)) u4 (
    .clk(clk), .reset(reset),
    .in_valid(iv4), .in_ready(ir4), .b_in(b4),
    .out_valid(ov4), .out_ready(or4), .x_out(x4),
    .out_idx(idx4), .out_last(last4),
    .converged(conv4), .iter_count(it4),
    .busy(busy4)
  );

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic longint g(input int j,
                               input int n);
    if (j < 0 || j >= n) return 0;
    return mx[j];
  endfunction

  // reference: A x = b solved by plain GS sweeps
  task automatic model(input int n, input int maxit);
    longint num, q;
    bit all;
    for (int k = 0; k < n; k++) mx[k] = mb[k] * 65536;
    m_it = 0;
    do begin
      all = 1;
      for (int i = 0; i < n; i++) begin
        num = mb[i] * 65536
            + 13 * (g(i-1, n) + g(i+1, n))
            - 6  * (g(i-2, n) + g(i+2, n))
            +      (g(i-3, n) + g(i+3, n));
        q = num / 20;
        if (num % 20 != 0 && num < 0) q = q - 1;
        if (q > 64'sd2147483647)  q = 64'sd2147483647;
        if (q < -64'sd2147483648) q = -64'sd2147483648;
        if ((q >>> 2) != (mx[i] >>> 2)) all = 0;
        mx[i] = q;
      end
      m_it++;
    end while (!all && m_it < maxit);
    m_conv = all;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset16(input string tag);
    chk({tag, "_in_ready"}, ir16, 1);
    chk({tag, "_out_valid"}, ov16, 0);
    chk({tag, "_busy"}, busy16, 0);
    chk({tag, "_x_out"}, x16, 0);
    chk({tag, "_out_idx"}, idx16, 0);
    chk({tag, "_out_last"}, last16, 0);
    chk({tag, "_conv"}, conv16, 0);
    chk({tag, "_iter"}, it16, 0);
  endtask

  task automatic load16(input bit junk);
    for (int k = 0; k < 16; k++) begin
      iv16 = 1;
      b16  = 16'(mb[k]);
      tick();
      if (k == 0) chk("busy_load", busy16, 1);
    end
    iv16 = junk;
    b16  = 16'($urandom);
    if (junk) chk("in_ready_iter", ir16, 0);
  endtask

  task automatic collect16(input bit bp, input bit junk);
    int e = 0;
    int c = 0;
    int t = 0;
    bit stalled = 0;
    logic [31:0] px;
    logic [3:0]  pi;
    while (!ov16 && t < 10000) begin
      b16 = 16'($urandom);
      tick();
      t++;
    end
    chk("out_valid_wait", ov16, 1);
    if (!ov16) return;
    while (e < 16 && c < 200) begin
      if (stalled) begin
        chk("stall_x", x16, px);
        chk("stall_idx", idx16, pi);
      end
      chk("out_valid", ov16, 1);
      chk("out_idx", idx16, e);
      chk("x_out", longint'($signed(x16)), mx[e]);
      chk("out_last", last16, e == 15);
      if (e == 0) begin
        chk("converged", conv16, m_conv);
        chk("iter_count", it16, m_it);
      end
      if (junk) chk("in_ready_out", ir16, 0);
      or16 = bp ? (c % 3 == 0) : 1'b1;
      if (junk && e == 15 && or16) iv16 = 0;
      b16 = 16'($urandom);
      stalled = !or16;
      px = x16;
      pi = idx16;
      if (or16) e++;
      c++;
      tick();
    end
    or16 = 0;
    iv16 = 0;
    chk("beats", e, 16);
    chk("idle_out_valid", ov16, 0);
    chk("idle_in_ready", ir16, 1);
  endtask

  task automatic rand_b(input int span);
    for (int k = 0; k < 16; k++)
      mb[k] = longint'($urandom_range(2*span, 0)) - span;
  endtask

  initial begin
    longint exp4 [4];
    int t;
    exp4[0] = 65536;
    exp4[1] = 42598;
    exp4[2] = 8027;
    exp4[3] = -4286;

    repeat (2) @(posedge clk);
    #1;
    chk_reset16("rst");
    reset = 0;
    tick();

    // all-zero rhs: converges after one sweep
    for (int k = 0; k < 16; k++) mb[k] = 0;
    model(16, 127);
    chk("zero_model_it", m_it, 1);
    load16(0);
    collect16(0, 0);

    // N=4, one sweep only
    for (int k = 0; k < 4; k++) begin
      iv4 = 1;
      b4  = (k == 0) ? 16'd20 : 16'd0;
      tick();
    end
    iv4 = 0;
    t = 0;
    while (!ov4 && t < 200) begin
      tick();
      t++;
    end
    chk("n4_out_valid", ov4, 1);
    or4 = 1;
    for (int e = 0; e < 4; e++) begin
      chk("n4_x", longint'($signed(x4)), exp4[e]);
      chk("n4_idx", idx4, e);
      chk("n4_last", last4, e == 3);
      chk("n4_conv", conv4, 0);
      chk("n4_iter", it4, 1);
      tick();
    end
    or4 = 0;
    chk("n4_idle", ov4, 0);

    // b = 1..16
    for (int k = 0; k < 16; k++) mb[k] = k + 1;
    model(16, 127);
    load16(0);
    collect16(0, 0);

    // random rhs with 1,0,0 backpressure
    rand_b(1000);
    model(16, 127);
    load16(0);
    collect16(1, 0);

    // junk on b_in while busy
    rand_b(30000);
    model(16, 127);
    load16(1);
    collect16(0, 1);

    // reset inside the second sweep
    for (int k = 0; k < 16; k++) mb[k] = k + 1;
    load16(0);
    repeat (72) tick();
    chk("mid_busy", busy16, 1);
    reset = 1;
    #1;
    chk_reset16("midrst");
    tick();
    reset = 0;
    tick();
    for (int k = 0; k < 16; k++) mb[k] = 0;
    model(16, 127);
    load16(0);
    collect16(0, 0);

    // more random problems, back to back
    for (int r = 0; r < 2; r++) begin
      rand_b(5000);
      model(16, 127);
      load16(0);
      collect16(r == 0, 0);
    end

    $display("%0d/%0d checks passed",
             checks - fails, checks);
    $finish;
  end

endmodule
